uart_ook_keyer: RTL and testbench

UART_OOK_KEYER -- requirements
Module: uart_ook_keyer

---
 rtl/uart_ook_keyer.sv | 183 ++++++++++++++++++
 tb/tb_uart_ook_keyer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_ook_keyer.sv
// Buffers UART bytes and keys each one as OOK: start(1), 8 data bits LSB first, 2 stop(0); o_KEY rises 2 cycles after an idle push.
// No backpressure: bytes arriving while full are dropped and flagged (sticky o_OVERFLOW). Macro OOK_PREAMBLE_EN adds a 1010_1010 preamble after IDLE.
module uart_ook_keyer #(
    parameter int CLOCK_RATE = 27_000_000,
    parameter int BIT_RATE   = 1_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_READY,
    input  logic [7:0] i_DATA,
    output logic       o_KEY,
    output logic       o_BUSY,
    output logic       o_FULL,
    output logic       o_OVERFLOW
);

    localparam int BIT_TICKS = CLOCK_RATE / BIT_RATE;
    localparam int TMR_W     = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
`ifdef OOK_PREAMBLE_EN
    localparam logic [2:0] S_PRE   = 3'd4;
    localparam logic [2:0] S_FIRST = S_PRE;
`else
    localparam logic [2:0] S_FIRST = S_START;
`endif

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_key;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_tick_end;
    logic w_stop_done;
    logic w_key_d;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_FULL);
    assign w_tick_end  = (r_timer == TMR_LAST);
    assign w_stop_done = (r_state == S_STOP) && w_tick_end && (r_bit == 3'd1);
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_stop_done);
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign w_push      = i_READY && (!w_full || w_pop);
    assign w_drop      = i_READY && w_full && !w_pop;

    always_ff @(posedge i_CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_DATA;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_FIRST;
                end
            end
`ifdef OOK_PREAMBLE_EN
            S_PRE: begin
                if (w_tick_end && (r_bit == 3'd7)) begin
                    w_state_nxt = S_START;
                end
            end
`endif
            S_START: begin
                if (w_tick_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick_end && (r_bit == 3'd7)) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_stop_done) begin
                    w_state_nxt = w_empty ? S_IDLE : S_START;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_key_d = 1'b0;
        case (r_state)
`ifdef OOK_PREAMBLE_EN
            S_PRE:   w_key_d = ~r_bit[0];
`endif
            S_START: w_key_d = 1'b1;
            S_DATA:  w_key_d = r_shift[0];
            default: w_key_d = 1'b0;
        endcase
    end

    // Timer and bit index restart whenever the state or the bit slot changes.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_timer <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_key   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) || w_tick_end) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
            if (r_state == S_IDLE) begin
                r_bit <= 3'd0;
            end else if (w_tick_end) begin
                r_bit <= (w_state_nxt != r_state) ? 3'd0 : r_bit + 3'd1;
            end
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end else if ((r_state == S_DATA) && w_tick_end) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
            r_key <= w_key_d;
        end
    end

    assign o_KEY      = r_key;
    assign o_BUSY     = (r_state != S_IDLE);
    assign o_FULL     = w_full;
    assign o_OVERFLOW = r_ovf;

endmodule

// File: tb/tb_uart_ook_keyer.sv
// Directed and random bench for uart_ook_keyer against a frame-level timeline model.
module tb_uart_ook_keyer;

    localparam int CR    = 16;
    localparam int BR    = 4;
    localparam int DEPTH = 4;
    localparam int BT    = CR / BR;
`ifdef OOK_PREAMBLE_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] dat = 8'h00;
    logic       o_key, o_busy, o_full, o_ovf;

    int pass_cnt = 0;
    int total    = 0;

    logic [7:0] q[$];
    int         busy_rem = 0;
    int         cur_len  = 0;
    logic [7:0] cur_b    = 8'h00;
    bit         cur_pre  = 1'b0;
    bit         m_ovf    = 1'b0;
    bit         m_key    = 1'b0;

    uart_ook_keyer #(.CLOCK_RATE(CR), .BIT_RATE(BR), .FIFO_DEPTH(DEPTH)) dut (
        .i_CLK(clk), .i_RST(rst), .i_READY(rdy), .i_DATA(dat),
        .o_KEY(o_key), .o_BUSY(o_busy), .o_FULL(o_full), .o_OVERFLOW(o_ovf)
    );

    always #5 clk = ~clk;

    // Symbol on air at offset t of a frame: optional 32-tick 1010.. preamble, start 1, data LSB first, two stop 0s.
    function automatic bit sym(input logic [7:0] b, input bit pre, input int t);
        int tt;
        int idx;
        tt = t;
        if (pre) begin
            if (tt < 8 * BT) return ((tt / BT) % 2) == 0;
            tt = tt - 8 * BT;
        end
        idx = tt / BT;
        if (idx == 0) return 1'b1;
        if (idx <= 8) return b[idx-1];
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total = total + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        busy_rem = 0;
        m_ovf    = 1'b0;
        m_key    = 1'b0;
    endtask

    task automatic model_edge();
        bit was_idle;
        bit popped;
        bit acc;
        int n;
        if (rst) begin
            model_reset();
            return;
        end
        m_key    = (busy_rem > 0) ? sym(cur_b, cur_pre, cur_len - busy_rem) : 1'b0;
        was_idle = (busy_rem == 0);
        if (busy_rem > 0) busy_rem = busy_rem - 1;
        n      = q.size();
        popped = (busy_rem == 0) && (n > 0);
        acc    = rdy && ((n < DEPTH) || popped);
        if (rdy && !acc) m_ovf = 1'b1;
        if (popped) begin
            cur_b    = q.pop_front();
            cur_pre  = PRE && was_idle;
            cur_len  = cur_pre ? 76 : 44;
            busy_rem = cur_len;
        end
        if (acc) q.push_back(dat);
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "_key"},  o_key,  m_key);
        chk({pfx, "_busy"}, o_busy, busy_rem > 0);
        chk({pfx, "_full"}, o_full, q.size() == DEPTH);
        chk({pfx, "_ovf"},  o_ovf,  m_ovf);
    endtask

    task automatic step(input logic r, input logic [7:0] d);
        rdy = r;
        dat = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    // Raise reset between edges, check the asynchronous clear, then hold it over an edge with i_READY high.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        step(1'b1, 8'h55);
        rst = 1'b0;
    endtask

    logic [10:0] a5_pat = 11'b00101001011;

    initial begin
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("init_rst");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single 0xA5 frame, also checked against the literal waveform.
        step(1'b1, 8'hA5);
        for (int k = 1; k <= 50; k++) begin
            step(1'b0, 8'h00);
`ifndef OOK_PREAMBLE_EN
            chk("a5_wave", o_key, (k >= 2 && k <= 45) ? a5_pat[(k-2)/4] : 1'b0);
            chk("a5_busy", o_busy, k <= 44);
`endif
        end

        // Back-to-back frames with no gap.
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        idle(140);

        // Overflow burst; flag must stay set until reset.
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
        chk("burst_full", o_full, 1'b1);
        chk("burst_ovf",  o_ovf,  1'b1);
        idle(260);
        chk("ovf_sticky", o_ovf, 1'b1);
        do_reset();
        chk("ovf_cleared", o_ovf, 1'b0);
        idle(20);

        // Reset during DATA bit 3 of 0x3C with two bytes queued.
        step(1'b1, 8'h3C);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        idle(16);
        chk("pre_rst_key", o_key, 1'b1);
        do_reset();
        chk("post_rst_busy", o_busy, 1'b0);
        idle(150);

        // Preamble behaviour (plain back-to-back frames in the default build).
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        idle(180);

        // Random traffic: sparse bytes plus occasional bursts that may overflow.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                for (int j = 0; j < 5; j++) step(1'b1, 8'($urandom));
            end else begin
                step($urandom_range(0, 39) == 0, 8'($urandom));
            end
        end
        idle(400);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
